muldiv_issue: RTL and testbench

MULDIV_ISSUE -- requirements
Module: muldiv_issue

---
 rtl/muldiv_pkg.sv | 35 +++
 rtl/muldiv_decode.sv | 36 +++
 rtl/muldiv_issue.sv | 121 ++++++++++++
 tb/tb_muldiv_issue.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants and types for the M-extension issue path: opcode/funct fields,
// one-hot operation indices and the issue FSM states.
package muldiv_pkg;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    F3_MUL    = 3'd0,
    F3_MULH   = 3'd1,
    F3_MULHSU = 3'd2,
    F3_MULHU  = 3'd3,
    F3_DIV    = 3'd4,
    F3_DIVU   = 3'd5,
    F3_REM    = 3'd6,
    F3_REMU   = 3'd7
  } funct3_e;

  localparam int unsigned IDX_MUL    = 0;
  localparam int unsigned IDX_MULH   = 1;
  localparam int unsigned IDX_MULHSU = 2;
  localparam int unsigned IDX_MULHU  = 3;
  localparam int unsigned IDX_DIV    = 4;
  localparam int unsigned IDX_DIVU   = 5;
  localparam int unsigned IDX_REM    = 6;
  localparam int unsigned IDX_REMU   = 7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WB
  } state_e;

endpackage

// File: rtl/muldiv_decode.sv
// Combinational RV32M decoder: flags legal MUL/DIV ops and produces the one-hot
// operation select consumed by the multiplier/divider.
module muldiv_decode
  import muldiv_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic        legal_o,
  output logic [7:0]  onehot_o
);

  funct3_e f3;
  logic    unused_fields;

  // Register specifiers are not part of the decode.
  assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

  always_comb begin
    f3       = funct3_e'(instr_i[14:12]);
    legal_o  = (instr_i[6:0] == OPC_OP) && (instr_i[31:25] == FUNCT7_MULDIV);
    onehot_o = '0;
    if (legal_o) begin
      case (f3)
        F3_MUL:    onehot_o[IDX_MUL]    = 1'b1;
        F3_MULH:   onehot_o[IDX_MULH]   = 1'b1;
        F3_MULHSU: onehot_o[IDX_MULHSU] = 1'b1;
        F3_MULHU:  onehot_o[IDX_MULHU]  = 1'b1;
        F3_DIV:    onehot_o[IDX_DIV]    = 1'b1;
        F3_DIVU:   onehot_o[IDX_DIVU]   = 1'b1;
        F3_REM:    onehot_o[IDX_REM]    = 1'b1;
        F3_REMU:   onehot_o[IDX_REMU]   = 1'b1;
        default:   onehot_o             = '0;
      endcase
    end
  end

endmodule

// File: rtl/muldiv_issue.sv
// Single-entry issue stage for the multiplier/divider: accepts one instruction,
// issues it, waits (with timeout) for the result and holds it for writeback.
module muldiv_issue
  import muldiv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_instr_i,
  input  logic [31:0] in_ra_i,
  input  logic [31:0] in_rb_i,

  output logic        md_valid_o,
  output logic [7:0]  md_inst_o,
  output logic [31:0] md_operand_ra_o,
  output logic [31:0] md_operand_rb_o,
  input  logic        md_stall_i,
  input  logic        md_ready_i,
  input  logic [31:0] md_result_i,

  output logic        wb_valid_o,
  input  logic        wb_ready_i,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_result_o,
  output logic        wb_illegal_o,
  output logic        wb_timeout_o
);

  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES) > 6) ? $clog2(TIMEOUT_CYCLES) : 6;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       onehot_q;
  logic [31:0]      ra_q;
  logic [31:0]      rb_q;
  logic [4:0]       rd_q;
  logic [31:0]      result_q;
  logic             illegal_q;
  logic             timeout_q;

  logic             dec_legal;
  logic [7:0]       dec_onehot;

  muldiv_decode u_decode (
    .instr_i  (in_instr_i),
    .legal_o  (dec_legal),
    .onehot_o (dec_onehot)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      onehot_q  <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      rd_q      <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid_i) begin
            onehot_q  <= dec_onehot;
            ra_q      <= in_ra_i;
            rb_q      <= in_rb_i;
            rd_q      <= in_instr_i[11:7];
            result_q  <= '0;
            timeout_q <= 1'b0;
            illegal_q <= ~dec_legal;
            state_q   <= dec_legal ? S_ISSUE : S_WB;
          end
        end
        S_ISSUE: begin
          if (!md_stall_i) begin
            cnt_q   <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A result arriving in the final counted cycle takes priority over the timeout.
          if (md_ready_i) begin
            result_q <= md_result_i;
            state_q  <= S_WB;
          end else if (cnt_q == CNT_LAST) begin
            result_q  <= '1;
            timeout_q <= 1'b1;
            state_q   <= S_WB;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_WB: begin
          if (wb_ready_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Handshake strobes are gated by reset so nothing is offered while it is asserted.
  always_comb begin
    in_ready_o      = (state_q == S_IDLE) && !rst_i;
    md_valid_o      = (state_q == S_ISSUE) && !md_stall_i && !rst_i;
    md_inst_o       = md_valid_o ? onehot_q : '0;
    md_operand_ra_o = md_valid_o ? ra_q : '0;
    md_operand_rb_o = md_valid_o ? rb_q : '0;
    wb_valid_o      = (state_q == S_WB) && !rst_i;
    wb_rd_o         = rd_q;
    wb_result_o     = result_q;
    wb_illegal_o    = illegal_q;
    wb_timeout_o    = timeout_q;
  end

endmodule

// File: tb/tb_muldiv_issue.sv
// Bench for muldiv_issue: directed and random instructions against an arithmetic
// reference of RV32M, with the bench acting as the multiplier/divider unit.
module tb_muldiv_issue;

  localparam int T = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_instr_i;
  logic [31:0] in_ra_i;
  logic [31:0] in_rb_i;
  logic        md_valid_o;
  logic [7:0]  md_inst_o;
  logic [31:0] md_operand_ra_o;
  logic [31:0] md_operand_rb_o;
  logic        md_stall_i;
  logic        md_ready_i;
  logic [31:0] md_result_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_result_o;
  logic        wb_illegal_o;
  logic        wb_timeout_o;

  int checks = 0;
  int errors = 0;

  muldiv_issue #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .in_valid_i      (in_valid_i),
    .in_ready_o      (in_ready_o),
    .in_instr_i      (in_instr_i),
    .in_ra_i         (in_ra_i),
    .in_rb_i         (in_rb_i),
    .md_valid_o      (md_valid_o),
    .md_inst_o       (md_inst_o),
    .md_operand_ra_o (md_operand_ra_o),
    .md_operand_rb_o (md_operand_rb_o),
    .md_stall_i      (md_stall_i),
    .md_ready_i      (md_ready_i),
    .md_result_i     (md_result_i),
    .wb_valid_o      (wb_valid_o),
    .wb_ready_i      (wb_ready_i),
    .wb_rd_o         (wb_rd_o),
    .wb_result_o     (wb_result_o),
    .wb_illegal_o    (wb_illegal_o),
    .wb_timeout_o    (wb_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // RV32M semantics, including divide-by-zero and signed-overflow results.
  function automatic logic [31:0] ref_op(input int f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'(b);
    case (f3)
      0: begin p = sa * sb; return p[31:0]; end
      1: begin p = sa * sb; return p[63:32]; end
      2: begin p = sa * ub; return p[63:32]; end
      3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int oh_idx(input logic [7:0] oh);
    for (int i = 0; i < 8; i++) if (oh[i]) return i;
    return 0;
  endfunction

  // delay: cycles after the issue cycle at which md_ready_i is raised (0 = never).
  task automatic run_op(input logic [31:0] instr, input logic [31:0] ra, input logic [31:0] rb,
                        input int stall, input int delay, input int hold, input string tag);
    logic        legal, exp_to;
    int          f3, issue_cyc, wb_cyc, pulses, cyc, exp_wb_cyc;
    logic [4:0]  rd;
    logic [31:0] exp_res, resp;
    legal   = (instr[6:0] == 7'b0110011) && (instr[31:25] == 7'b0000001);
    f3      = int'(instr[14:12]);
    rd      = instr[11:7];
    exp_to  = legal && (delay == 0 || delay > T);
    exp_res = !legal ? 32'd0 : (exp_to ? 32'hFFFF_FFFF : ref_op(f3, ra, rb));

    @(negedge clk_i);
    in_valid_i = 1'b1; in_instr_i = instr; in_ra_i = ra; in_rb_i = rb; wb_ready_i = 1'b0;
    #1 check({tag, "_in_ready"}, 32'(in_ready_o), 32'd1);
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0; in_instr_i = $urandom; in_ra_i = $urandom; in_rb_i = $urandom;

    issue_cyc = -1; wb_cyc = -1; pulses = 0; cyc = 0; resp = '0;
    while (wb_cyc < 0 && cyc < 200) begin
      @(negedge clk_i);
      cyc++;
      md_stall_i = (issue_cyc < 0) && (cyc <= stall);
      if (issue_cyc < 0) begin
        md_ready_i  = 1'b1;          // must be ignored before WAIT
        md_result_i = 32'h0BAD_0BAD;
      end else begin
        md_ready_i  = (delay != 0) && (cyc == issue_cyc + delay);
        md_result_i = md_ready_i ? resp : $urandom;
      end
      #1;
      if (md_valid_o) begin
        pulses++;
        issue_cyc = cyc;
        check({tag, "_md_inst"}, 32'(md_inst_o), 32'(8'h01 << f3));
        check({tag, "_md_ra"}, md_operand_ra_o, ra);
        check({tag, "_md_rb"}, md_operand_rb_o, rb);
        resp = ref_op(oh_idx(md_inst_o), md_operand_ra_o, md_operand_rb_o);
      end else begin
        check({tag, "_md_inst_idle"}, 32'(md_inst_o), 32'd0);
      end
      check({tag, "_in_ready_busy"}, 32'(in_ready_o), 32'd0);
      if (wb_valid_o) wb_cyc = cyc;
    end
    md_ready_i = 1'b0;
    md_stall_i = 1'b0;

    exp_wb_cyc = !legal ? 1 : (exp_to ? stall + 1 + T + 1 : stall + 1 + delay + 1);
    check({tag, "_pulses"}, 32'(pulses), legal ? 32'd1 : 32'd0);
    check({tag, "_wb_latency"}, 32'(wb_cyc), 32'(exp_wb_cyc));
    check({tag, "_wb_rd"}, 32'(wb_rd_o), 32'(rd));
    check({tag, "_wb_result"}, wb_result_o, exp_res);
    check({tag, "_wb_illegal"}, 32'(wb_illegal_o), 32'(!legal));
    check({tag, "_wb_timeout"}, 32'(wb_timeout_o), 32'(exp_to));

    for (int h = 0; h < hold; h++) begin
      @(negedge clk_i);
      #1;
      check({tag, "_hold_valid"}, 32'(wb_valid_o), 32'd1);
      check({tag, "_hold_result"}, wb_result_o, exp_res);
      check({tag, "_hold_rd"}, 32'(wb_rd_o), 32'(rd));
      check({tag, "_hold_flags"}, 32'({wb_illegal_o, wb_timeout_o}), 32'({!legal, exp_to}));
      check({tag, "_hold_in_ready"}, 32'(in_ready_o), 32'd0);
    end
    @(negedge clk_i);
    wb_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    wb_ready_i = 1'b0;
    check({tag, "_post_wb_valid"}, 32'(wb_valid_o), 32'd0);
    check({tag, "_post_in_ready"}, 32'(in_ready_o), 32'd1);
  endtask

  initial begin
    logic [31:0] instr, ra, rb;

    rst_i = 1'b1; in_valid_i = 1'b0; in_instr_i = '0; in_ra_i = '0; in_rb_i = '0;
    md_stall_i = 1'b0; md_ready_i = 1'b0; md_result_i = '0; wb_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    check("rst_in_ready", 32'(in_ready_o), 32'd0);
    check("rst_md_valid", 32'(md_valid_o), 32'd0);
    check("rst_md_inst", 32'(md_inst_o), 32'd0);
    check("rst_md_ops", md_operand_ra_o | md_operand_rb_o, 32'd0);
    check("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    check("rst_wb_result", wb_result_o, 32'd0);
    check("rst_wb_misc", 32'({wb_rd_o, wb_illegal_o, wb_timeout_o}), 32'd0);
    rst_i = 1'b0;
    #1 check("rst_release_ready", 32'(in_ready_o), 32'd1);

    run_op(32'h02B5_0533, 32'd7, 32'd6, 0, 2, 0, "mul");
    run_op(32'h02B5_4533, 32'd100, 32'd7, 3, 1, 0, "div_stall");
    run_op(32'h00B5_0533, 32'd3, 32'd4, 0, 1, 0, "add_illegal");
    run_op(32'h02B5_7533, 32'd9, 32'd5, 0, 0, 0, "remu_timeout");
    run_op(32'h02B5_3533, 32'hDEAD_BEEF, 32'h1234_5678, 1, 3, 5, "mulhu_backpressure");
    run_op(32'h02B5_5533, 32'd50, 32'd5, 0, T, 0, "divu_ready_at_limit");
    run_op(32'h02B5_4033, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 1, "div_ovf_rd0");
    run_op(32'h02B5_6533, 32'hFFFF_FFF9, 32'd0, 0, 1, 0, "rem_by_zero");

    // Reset while waiting for the unit; its late answer must be dropped.
    @(negedge clk_i);
    in_valid_i = 1'b1; in_instr_i = 32'h02B5_0533; in_ra_i = 32'd2; in_rb_i = 32'd3;
    @(posedge clk_i);
    #1 in_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check("rstw_in_ready", 32'(in_ready_o), 32'd0);
    check("rstw_wb_valid", 32'(wb_valid_o), 32'd0);
    check("rstw_md_valid", 32'(md_valid_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    md_ready_i = 1'b1; md_result_i = 32'h5555_AAAA;
    @(negedge clk_i);
    #1 check("rstw_ready_after", 32'(in_ready_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      md_ready_i = (i % 2) == 0;
      #1;
      check("rstw_no_wb", 32'(wb_valid_o), 32'd0);
      check("rstw_no_issue", 32'(md_valid_o), 32'd0);
    end
    md_ready_i = 1'b0;

    for (int n = 0; n < 24; n++) begin
      instr = {7'b0000001, 5'($urandom), 5'($urandom), 3'($urandom_range(0, 7)),
               5'($urandom), 7'b0110011};
      if ($urandom_range(0, 5) == 0) instr[31:25] = 7'($urandom_range(2, 127));
      if ($urandom_range(0, 7) == 0) instr[6:0] = 7'b0010011;
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 7) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      run_op(instr, ra, rb, $urandom_range(0, 3),
             ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, T), $urandom_range(0, 3), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
